// File: rtl/if_id_stage_buffer_if.sv
// Handshake and data bundle between IF, the IF/ID stage buffer and ID.
// slave is the buffer's view; master is the IF/ID environment's view.
interface if_id_stage_buffer_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 2
);
  logic               flush;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc_in;
  logic [INSTR_W-1:0] if_instr_in;
  logic               if_ready;
  logic               id_ready;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc_out;
  logic [INSTR_W-1:0] id_instr_out;
  logic [CNT_W-1:0]   occupancy;
  logic [1:0]         ExtSelect_out;
  logic               id_GPR_we;
  logic [4:0]         id_GPR_waddr;
  logic [1:0]         id_GPR_wdata_select;

  modport slave (
    input  flush, if_valid, if_pc_in, if_instr_in, id_ready,
    output if_ready, id_valid, id_pc_out, id_instr_out, occupancy,
           ExtSelect_out, id_GPR_we, id_GPR_waddr, id_GPR_wdata_select
  );

  modport master (
    output flush, if_valid, if_pc_in, if_instr_in, id_ready,
    input  if_ready, id_valid, id_pc_out, id_instr_out, occupancy,
           ExtSelect_out, id_GPR_we, id_GPR_waddr, id_GPR_wdata_select
  );
endinterface

// File: rtl/if_id_stage_buffer.sv
// IF->ID stage as a DEPTH-entry FIFO with valid/ready on both sides, flush,
// occupancy, and a predecode of the head instruction for the hazard unit.
module if_id_stage_buffer #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  if_id_stage_buffer_if.slave  bus
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic head_valid, room, push, pop;
  logic [5:0] op, fn;
  logic [4:0] rt, rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [4:0] gpr_waddr(input logic [5:0] o,
                                           input logic [4:0] t,
                                           input logic [4:0] d);
    if (o == 6'b000011)      return 5'd31;
    else if (o == 6'b000000) return d;
    else                     return t;
  endfunction

  function automatic logic gpr_we(input logic [5:0] o, input logic [5:0] f);
    casez (o)
      6'b000000: return (f != 6'b001000);
      6'b101011,
      6'b0001??,
      6'b000010: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] wdata_sel(input logic [5:0] o);
    case (o)
      6'b000011: return 2'b10;
      6'b100011: return 2'b01;
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ext_sel(input logic [5:0] o);
    casez (o)
      6'b000000,
      6'b0001??: return 2'b10;
      6'b001100,
      6'b001101,
      6'b001110: return 2'b01;
      6'b001111: return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  // Handshake: ready depends on held state only, never on id_ready.
  assign head_valid = (count != '0);
  assign room       = (count < FULL);
  assign push       = bus.if_valid & room & ~bus.flush;
  assign pop        = head_valid & bus.id_ready & ~bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= bus.if_pc_in;
        instr_mem[wr_ptr] <= bus.if_instr_in;
        wr_ptr            <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Head presentation: an empty stage shows an all-zero NOP.
  assign bus.if_ready     = room;
  assign bus.id_valid     = head_valid;
  assign bus.occupancy    = count;
  assign bus.id_pc_out    = head_valid ? pc_mem[rd_ptr]    : '0;
  assign bus.id_instr_out = head_valid ? instr_mem[rd_ptr] : '0;

  assign op = bus.id_instr_out[31:26];
  assign rt = bus.id_instr_out[20:16];
  assign rd = bus.id_instr_out[15:11];
  assign fn = bus.id_instr_out[5:0];

  assign bus.id_GPR_waddr        = head_valid ? gpr_waddr(op, rt, rd) : 5'd0;
  assign bus.id_GPR_we           = head_valid & gpr_we(op, fn);
  assign bus.id_GPR_wdata_select = head_valid ? wdata_sel(op) : 2'b00;
  assign bus.ExtSelect_out       = head_valid ? ext_sel(op)   : 2'b00;

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Directed bench for if_id_stage_buffer (DEPTH=2): reset, back-pressure,
// streaming, flush, predecode and asynchronous reset during traffic.
module tb_if_id_stage_buffer;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  if_id_stage_buffer_if #(.PC_W(32), .INSTR_W(32), .CNT_W(2)) bus ();

  if_id_stage_buffer #(.PC_W(32), .INSTR_W(32), .DEPTH(2), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush       = 1'b0;
    bus.if_valid    = 1'b0;
    bus.if_pc_in    = '0;
    bus.if_instr_in = '0;
    bus.id_ready    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    step(); step();
    reset = 1'b1;
    step();
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.id_valid); else n_pass++;
    n_total++; if (bus.if_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", bus.if_ready); else n_pass++;
    n_total++; if (bus.occupancy !== 2'd0) $display("FAIL rst_occ got %0d exp 0", bus.occupancy); else n_pass++;
    n_total++; if (bus.id_instr_out !== 32'h0) $display("FAIL rst_instr got %h exp 0", bus.id_instr_out); else n_pass++;
    n_total++; if (bus.id_GPR_we !== 1'b0) $display("FAIL rst_we got %b exp 0", bus.id_GPR_we); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.id_ready = 1'b0;
    bus.if_valid = 1'b1; bus.if_pc_in = 32'h0; bus.if_instr_in = 32'hA0000000;
    step();
    n_total++; if (bus.occupancy !== 2'd1) $display("FAIL bp_occ1 got %0d exp 1", bus.occupancy); else n_pass++;
    n_total++; if (bus.id_valid !== 1'b1) $display("FAIL bp_latency got %b exp 1", bus.id_valid); else n_pass++;
    bus.if_pc_in = 32'h4; bus.if_instr_in = 32'hA0000004;
    step();
    n_total++; if (bus.occupancy !== 2'd2) $display("FAIL bp_occ2 got %0d exp 2", bus.occupancy); else n_pass++;
    n_total++; if (bus.if_ready !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", bus.if_ready); else n_pass++;
    bus.if_pc_in = 32'h8; bus.if_instr_in = 32'hA0000008;
    step();
    n_total++; if (bus.occupancy !== 2'd2) $display("FAIL bp_no_third got %0d exp 2", bus.occupancy); else n_pass++;
    n_total++; if (bus.id_pc_out !== 32'h0) $display("FAIL bp_head0 got %h exp 0", bus.id_pc_out); else n_pass++;
    bus.id_ready = 1'b1;
    step();
    n_total++; if (bus.id_pc_out !== 32'h4) $display("FAIL bp_head4 got %h exp 4", bus.id_pc_out); else n_pass++;
    n_total++; if (bus.occupancy !== 2'd1) $display("FAIL bp_occ_after_pop got %0d exp 1", bus.occupancy); else n_pass++;
    step();
    n_total++; if (bus.id_pc_out !== 32'h8) $display("FAIL bp_head8 got %h exp 8", bus.id_pc_out); else n_pass++;
    n_total++; if (bus.id_instr_out !== 32'hA0000008) $display("FAIL bp_instr8 got %h exp A0000008", bus.id_instr_out); else n_pass++;
    bus.if_valid = 1'b0;
    step();
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", bus.id_valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_streaming();
    bus.if_valid = 1'b1;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.if_pc_in    = 32'(4 * i);
      bus.if_instr_in = 32'h20000000 + 32'(i);
      step();
      n_total++; if (bus.id_pc_out !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.id_pc_out, 32'(4 * i)); else n_pass++;
      n_total++; if (bus.occupancy !== 2'd1) $display("FAIL stream_occ[%0d] got %0d exp 1", i, bus.occupancy); else n_pass++;
    end
    bus.if_valid = 1'b0;
    step();
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", bus.id_valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_flush();
    bus.if_valid = 1'b1;
    bus.if_pc_in = 32'h100; step();
    bus.if_pc_in = 32'h104; step();
    n_total++; if (bus.occupancy !== 2'd2) $display("FAIL fl_pre_occ got %0d exp 2", bus.occupancy); else n_pass++;
    bus.if_pc_in = 32'h108; bus.flush = 1'b1; bus.id_ready = 1'b1;
    step();
    bus.flush = 1'b0; bus.if_valid = 1'b0; bus.id_ready = 1'b0;
    n_total++; if (bus.occupancy !== 2'd0) $display("FAIL fl_occ got %0d exp 0", bus.occupancy); else n_pass++;
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL fl_valid got %b exp 0", bus.id_valid); else n_pass++;
    // One held entry plus a beat that would otherwise be accepted.
    bus.if_valid = 1'b1; bus.if_pc_in = 32'h10C; step();
    bus.if_pc_in = 32'h110; bus.flush = 1'b1; step();
    bus.flush = 1'b0; bus.if_valid = 1'b0;
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL fl_drop_valid got %b exp 0", bus.id_valid); else n_pass++;
    step();
    n_total++; if (bus.occupancy !== 2'd0) $display("FAIL fl_drop_later got %0d exp 0", bus.occupancy); else n_pass++;
    bus.if_valid = 1'b1; bus.if_pc_in = 32'h200; step();
    bus.if_valid = 1'b0;
    n_total++; if (bus.id_pc_out !== 32'h200) $display("FAIL fl_resume got %h exp 200", bus.id_pc_out); else n_pass++;
    bus.id_ready = 1'b1; step();
    idle_inputs();
  endtask

  task automatic test_predecode();
    logic [31:0] instr [10];
    logic [9:0]  expv  [10];   // {we, waddr, wsel, ext}
    logic [9:0]  got;
    instr[0] = 32'h0C000010; expv[0] = {1'b1, 5'd31, 2'b10, 2'b00}; // jal
    instr[1] = 32'h8C430004; expv[1] = {1'b1, 5'd3,  2'b01, 2'b00}; // lw
    instr[2] = 32'h03E00008; expv[2] = {1'b0, 5'd0,  2'b00, 2'b10}; // jr
    instr[3] = 32'h34A5FFFF; expv[3] = {1'b1, 5'd5,  2'b00, 2'b01}; // ori
    instr[4] = 32'h3C011234; expv[4] = {1'b1, 5'd1,  2'b00, 2'b11}; // lui
    instr[5] = 32'h10220003; expv[5] = {1'b0, 5'd2,  2'b00, 2'b10}; // beq
    instr[6] = 32'hAC220000; expv[6] = {1'b0, 5'd2,  2'b00, 2'b00}; // sw
    instr[7] = 32'h20420001; expv[7] = {1'b1, 5'd2,  2'b00, 2'b00}; // addi
    instr[8] = 32'h00221820; expv[8] = {1'b1, 5'd3,  2'b00, 2'b10}; // add
    instr[9] = 32'h08000004; expv[9] = {1'b0, 5'd0,  2'b00, 2'b00}; // j
    for (int i = 0; i < 10; i++) begin
      bus.id_ready = 1'b0;
      bus.if_valid = 1'b1; bus.if_pc_in = 32'h400 + 32'(4 * i); bus.if_instr_in = instr[i];
      step();
      bus.if_valid = 1'b0;
      got = {bus.id_GPR_we, bus.id_GPR_waddr, bus.id_GPR_wdata_select, bus.ExtSelect_out};
      n_total++; if (got !== expv[i]) $display("FAIL predecode[%0d] instr %h got %b exp %b", i, instr[i], got, expv[i]); else n_pass++;
      bus.id_ready = 1'b1;
      step();
    end
    got = {bus.id_GPR_we, bus.id_GPR_waddr, bus.id_GPR_wdata_select, bus.ExtSelect_out};
    n_total++; if (got !== 10'b0) $display("FAIL predecode_empty got %b exp 0", got); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.if_valid = 1'b1;
    bus.if_pc_in = 32'h500; bus.if_instr_in = 32'h0C000010; step();
    bus.if_pc_in = 32'h504; step();
    bus.id_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_total++; if (bus.occupancy !== 2'd0) $display("FAIL arst_occ got %0d exp 0", bus.occupancy); else n_pass++;
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", bus.id_valid); else n_pass++;
    n_total++; if (bus.id_pc_out !== 32'h0) $display("FAIL arst_pc got %h exp 0", bus.id_pc_out); else n_pass++;
    n_total++; if (bus.id_GPR_we !== 1'b0) $display("FAIL arst_we got %b exp 0", bus.id_GPR_we); else n_pass++;
    n_total++; if (bus.if_ready !== 1'b1) $display("FAIL arst_ready got %b exp 1", bus.if_ready); else n_pass++;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL arst_release_valid got %b exp 0", bus.id_valid); else n_pass++;
    n_total++; if (bus.occupancy !== 2'd0) $display("FAIL arst_release_occ got %0d exp 0", bus.occupancy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_streaming();
    test_flush();
    test_predecode();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
